// File: rtl/clock_bringup_pkg.sv
// Shared constants for the clock bring-up sequencer: FSM states, gpio bit
// positions toward/from the clock/reset block, and failure codes.
package clock_bringup_pkg;

    localparam int CNT_W = 24;

    // FSM state encoding
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_TCXO_RST  = 4'd1;
    localparam logic [3:0] S_TCXO_WAIT = 4'd2;
    localparam logic [3:0] S_CLK_WAIT  = 4'd3;
    localparam logic [3:0] S_GATE      = 4'd4;
    localparam logic [3:0] S_SETTLE    = 4'd5;
    localparam logic [3:0] S_CHECK     = 4'd6;
    localparam logic [3:0] S_RELEASE   = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;
    localparam logic [3:0] S_FAIL      = 4'd9;

    // gpio_o bit map
    localparam int GPO_SYS_RST    = 0;
    localparam int GPO_TCXO_RST   = 2;
    localparam int GPO_CLK_SEL    = 5;
    localparam int GPO_CLK_FMEAS  = 7;
    localparam int GPO_MCLK_SEL   = 35;
    localparam int GPO_MCLK_FMEAS = 37;

    // gpio_i bit map
    localparam int GPI_TCXO_LOCK = 3;
    localparam int GPI_CLK_LOCK  = 6;
    localparam int GPI_CLK_CNT   = 8;
    localparam int GPI_MCLK_LOCK = 36;
    localparam int GPI_MCLK_CNT  = 38;

    // err_code values
    localparam logic [2:0] ERR_NONE         = 3'd0;
    localparam logic [2:0] ERR_TCXO_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_CLK_TIMEOUT  = 3'd2;
    localparam logic [2:0] ERR_MCLK_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_CLK_RANGE    = 3'd4;
    localparam logic [2:0] ERR_MCLK_RANGE   = 3'd5;
    localparam logic [2:0] ERR_LOCK_LOST    = 3'd6;

endpackage

// File: rtl/clock_bringup_range_chk.sv
// Inclusive window compare of a frequency count: lo <= value <= hi.
module clock_bringup_range_chk
    import clock_bringup_pkg::*;
(
    input  logic [CNT_W-1:0] value,
    input  logic [CNT_W-1:0] lo,
    input  logic [CNT_W-1:0] hi,
    output logic             in_range
);

    assign in_range = (value >= lo) && (value <= hi);

endmodule

// File: rtl/clock_bringup_seq.sv
// Clock bring-up sequencer: resets the TCXO PLL, waits for locks, measures
// clk/mclk frequency over a gate window and releases sys_reset on success.
module clock_bringup_seq
    import clock_bringup_pkg::*;
#(
    parameter int               RST_CYCLES    = 16,
    parameter int               LOCK_TIMEOUT  = 1000000,
    parameter int               GATE_CYCLES   = 100000,
    parameter int               SETTLE_CYCLES = 8,
    parameter logic [CNT_W-1:0] CLK_FMIN      = 24'd0,
    parameter logic [CNT_W-1:0] CLK_FMAX      = 24'hFFFFFF,
    parameter logic [CNT_W-1:0] MCLK_FMIN     = 24'd0,
    parameter logic [CNT_W-1:0] MCLK_FMAX     = 24'hFFFFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clk_sel,
    input  logic             mclk_sel,
    output logic [63:0]      gpio_o,
    input  logic [63:0]      gpio_i,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] clk_count,
    output logic [CNT_W-1:0] mclk_count
);

    localparam logic [31:0] RST_LAST    = 32'(RST_CYCLES - 1);
    localparam logic [31:0] TO_LAST     = 32'(LOCK_TIMEOUT - 1);
    localparam logic [31:0] GATE_LAST   = 32'(GATE_CYCLES - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

    logic [3:0]  state, state_nxt;
    logic [2:0]  err_nxt;
    logic [31:0] cnt;
    logic        clk_sel_q, mclk_sel_q;
    logic        tcxo_seen, clk_seen, mclk_seen;
    logic        tcxo_lock, clk_lock, mclk_lock;
    logic        start_ok, monitor, lock_lost;
    logic        clk_ok, mclk_ok;
    logic        unused_gpio;

    assign tcxo_lock = gpio_i[GPI_TCXO_LOCK];
    assign clk_lock  = gpio_i[GPI_CLK_LOCK];
    assign mclk_lock = gpio_i[GPI_MCLK_LOCK];
    assign unused_gpio = ^{gpio_i[63:62], gpio_i[37], gpio_i[35:32], gpio_i[7],
                           gpio_i[5:4], gpio_i[2:0]};

    assign start_ok = start && (state == S_IDLE || state == S_DONE || state == S_FAIL);
    // Lock supervision covers everything from TCXO_WAIT through DONE.
    assign monitor  = !(state == S_IDLE || state == S_TCXO_RST || state == S_FAIL);
    assign lock_lost = monitor && ((tcxo_seen && !tcxo_lock) ||
                                   (clk_seen  && !clk_lock)  ||
                                   (mclk_seen && !mclk_lock));

    clock_bringup_range_chk u_clk_chk (
        .value    (clk_count),
        .lo       (CLK_FMIN),
        .hi       (CLK_FMAX),
        .in_range (clk_ok)
    );

    clock_bringup_range_chk u_mclk_chk (
        .value    (mclk_count),
        .lo       (MCLK_FMIN),
        .hi       (MCLK_FMAX),
        .in_range (mclk_ok)
    );

    always_comb begin
        state_nxt = state;
        err_nxt   = err_code;
        case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start_ok) begin
                    state_nxt = S_TCXO_RST;
                    err_nxt   = ERR_NONE;
                end
            end
            S_TCXO_RST:  if (cnt >= RST_LAST) state_nxt = S_TCXO_WAIT;
            S_TCXO_WAIT: begin
                if (tcxo_lock) begin
                    state_nxt = S_CLK_WAIT;
                end else if (cnt >= TO_LAST) begin
                    state_nxt = S_FAIL;
                    err_nxt   = ERR_TCXO_TIMEOUT;
                end
            end
            S_CLK_WAIT: begin
                if (clk_lock && mclk_lock) begin
                    state_nxt = S_GATE;
                end else if (cnt >= TO_LAST) begin
                    state_nxt = S_FAIL;
                    err_nxt   = clk_lock ? ERR_MCLK_TIMEOUT : ERR_CLK_TIMEOUT;
                end
            end
            S_GATE:   if (cnt >= GATE_LAST)   state_nxt = S_SETTLE;
            S_SETTLE: if (cnt >= SETTLE_LAST) state_nxt = S_CHECK;
            S_CHECK: begin
                if (!clk_ok) begin
                    state_nxt = S_FAIL;
                    err_nxt   = ERR_CLK_RANGE;
                end else if (!mclk_ok) begin
                    state_nxt = S_FAIL;
                    err_nxt   = ERR_MCLK_RANGE;
                end else begin
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: state_nxt = S_DONE;
            default:   state_nxt = S_IDLE;
        endcase
        // Lock loss overrides any timeout; a restart from DONE still wins.
        if (lock_lost && !start_ok) begin
            state_nxt = S_FAIL;
            err_nxt   = ERR_LOCK_LOST;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            err_code   <= ERR_NONE;
            cnt        <= '0;
            clk_sel_q  <= 1'b0;
            mclk_sel_q <= 1'b0;
            tcxo_seen  <= 1'b0;
            clk_seen   <= 1'b0;
            mclk_seen  <= 1'b0;
            clk_count  <= '0;
            mclk_count <= '0;
        end else begin
            state    <= state_nxt;
            err_code <= err_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + 32'd1;
            if (start_ok) begin
                clk_sel_q  <= clk_sel;
                mclk_sel_q <= mclk_sel;
                tcxo_seen  <= 1'b0;
                clk_seen   <= 1'b0;
                mclk_seen  <= 1'b0;
            end else if (monitor) begin
                tcxo_seen <= tcxo_seen | tcxo_lock;
                clk_seen  <= clk_seen  | clk_lock;
                mclk_seen <= mclk_seen | mclk_lock;
            end
            if (state == S_SETTLE && cnt >= SETTLE_LAST) begin
                clk_count  <= gpio_i[GPI_CLK_CNT  +: CNT_W];
                mclk_count <= gpio_i[GPI_MCLK_CNT +: CNT_W];
            end
        end
    end

    // Outputs decode straight from state so reset takes effect immediately.
    always_comb begin
        gpio_o                 = '0;
        gpio_o[GPO_SYS_RST]    = !(state == S_RELEASE || state == S_DONE);
        gpio_o[GPO_TCXO_RST]   = (state == S_TCXO_RST);
        gpio_o[GPO_CLK_SEL]    = clk_sel_q;
        gpio_o[GPO_CLK_FMEAS]  = (state == S_GATE);
        gpio_o[GPO_MCLK_SEL]   = mclk_sel_q;
        gpio_o[GPO_MCLK_FMEAS] = (state == S_GATE);
    end

    assign busy  = !(state == S_IDLE || state == S_DONE || state == S_FAIL);
    assign done  = (state == S_DONE);
    assign error = (state == S_FAIL);

endmodule

// File: tb/tb_clock_bringup_seq.sv
// Bench for clock_bringup_seq: table of bring-up scenarios scored through a
// queue, plus hand sequences for lock loss, mid-gate start and async reset.
module tb_clock_bringup_seq;

    localparam int RST    = 4;
    localparam int TO     = 100;
    localparam int GATE   = 20;
    localparam int SETTLE = 3;
    localparam int NEVER  = 100000;

    logic        clk = 1'b0;
    logic        reset, start, clk_sel, mclk_sel;
    logic [63:0] gpio_o, gpio_i;
    logic        busy, done, error;
    logic [2:0]  err_code;
    logic [23:0] clk_count, mclk_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          td, cd, md;
        logic [23:0] ccnt, mcnt;
        logic        csel, msel, poke;
        logic        exp_done;
        logic [2:0]  exp_err;
        int          exp_cyc, exp_gate;
        logic [23:0] exp_ccnt, exp_mcnt;
    } vec_t;

    vec_t vecs[11];
    vec_t exp_q[$];

    clock_bringup_seq #(
        .RST_CYCLES(RST), .LOCK_TIMEOUT(TO), .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE),
        .CLK_FMIN(24'd4900), .CLK_FMAX(24'd5100), .MCLK_FMIN(24'd4900), .MCLK_FMAX(24'd5100)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .clk_sel(clk_sel), .mclk_sel(mclk_sel),
        .gpio_o(gpio_o), .gpio_i(gpio_i), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .clk_count(clk_count), .mclk_count(mclk_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        vec_t  e;
        int    w, n, g, g37;
        logic  fin;
        string p;
        p = $sformatf("v%0d", idx);
        exp_q.push_back(v);
        @(negedge clk);
        start = 1'b1; clk_sel = v.csel; mclk_sel = v.msel;
        @(negedge clk);
        start  = 1'b0;
        gpio_i = '0;
        gpio_i[31:8]  = v.ccnt;
        gpio_i[61:38] = v.mcnt;
        chk({p, "_sel_latch"}, {62'd0, gpio_o[35], gpio_o[5]}, {62'd0, v.msel, v.csel});
        w = 0;
        while (gpio_o[2] === 1'b1 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk({p, "_rst_width"}, w, RST);
        n = 0; g = 0; g37 = 0; fin = 1'b0;
        while (!fin && n < 2000) begin
            start = 1'b0;
            if (done || error) begin
                fin = 1'b1;
            end else begin
                if (n == 0) chk({p, "_busy"}, busy, 1);
                if (gpio_o[7])  g++;
                if (gpio_o[37]) g37++;
                if (v.poke && g == 5 && gpio_o[7]) start = 1'b1;
                if (n == v.td)              gpio_i[3]  = 1'b1;
                if (n == v.td + 1 + v.cd)   gpio_i[6]  = 1'b1;
                if (n == v.td + 1 + v.md)   gpio_i[36] = 1'b1;
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        chk({p, "_finished"}, fin, 1);
        chk({p, "_sb_depth"}, exp_q.size(), 1);
        e = exp_q.pop_front();
        chk({p, "_cycles"},   n,          e.exp_cyc);
        chk({p, "_done"},     done,       e.exp_done);
        chk({p, "_error"},    error,      !e.exp_done);
        chk({p, "_err_code"}, err_code,   e.exp_err);
        chk({p, "_sys_rst"},  gpio_o[0],  !e.exp_done);
        chk({p, "_tcxo_rst"}, gpio_o[2],  0);
        chk({p, "_idle_bsy"}, busy,       0);
        chk({p, "_gate"},     g,          e.exp_gate);
        chk({p, "_gate_m"},   g37,        e.exp_gate);
        chk({p, "_clk_cnt"},  clk_count,  e.exp_ccnt);
        chk({p, "_mclk_cnt"}, mclk_count, e.exp_mcnt);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //         td     cd     md     ccnt      mcnt      cs    ms    poke  done  err   cyc  gate cnt_c     cnt_m
        vecs[0]  = '{50,    50,    50,    24'd5000, 24'd5000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 127, 20, 24'd5000, 24'd5000};
        vecs[1]  = '{NEVER, 0,     0,     24'd1234, 24'd1234, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 100, 0,  24'd5000, 24'd5000};
        vecs[2]  = '{10,    5,     5,     24'd5000, 24'd6000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 41,  20, 24'd5000, 24'd6000};
        vecs[3]  = '{0,     0,     0,     24'd4899, 24'd5000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 26,  20, 24'd4899, 24'd5000};
        vecs[4]  = '{3,     7,     7,     24'd4900, 24'd5100, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 37,  20, 24'd4900, 24'd5100};
        vecs[5]  = '{2,     NEVER, 0,     24'd5000, 24'd5000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 103, 0,  24'd4900, 24'd5100};
        vecs[6]  = '{2,     0,     NEVER, 24'd5000, 24'd5000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 103, 0,  24'd4900, 24'd5100};
        vecs[7]  = '{2,     NEVER, NEVER, 24'd5000, 24'd5000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 103, 0,  24'd4900, 24'd5100};
        vecs[8]  = '{1,     1,     1,     24'd5101, 24'd5000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 28,  20, 24'd5101, 24'd5000};
        vecs[9]  = '{4,     2,     6,     24'd5100, 24'd4899, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 36,  20, 24'd5100, 24'd4899};
        vecs[10] = '{5,     5,     5,     24'd5000, 24'd4900, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 37,  20, 24'd5000, 24'd4900};

        reset = 1'b1; start = 1'b0; clk_sel = 1'b0; mclk_sel = 1'b0; gpio_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_gpio_o",   gpio_o,     64'h1);
        chk("rst_busy",     busy,       0);
        chk("rst_done",     done,       0);
        chk("rst_error",    error,      0);
        chk("rst_err_code", err_code,   0);
        chk("rst_clk_cnt",  clk_count,  0);
        chk("rst_mclk_cnt", mclk_count, 0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Sequence ends in DONE with all locks held; drop clk lock.
        gpio_i[6] = 1'b0;
        @(negedge clk);
        chk("ll_error",    error,     1);
        chk("ll_err_code", err_code,  6);
        chk("ll_sys_rst",  gpio_o[0], 1);
        chk("ll_done",     done,      0);

        // Restart from FAIL and hit reset while the TCXO reset pulse is high.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ar_pulse_on", gpio_o[2], 1);
        chk("ar_err_clr",  err_code,  0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ar_tcxo_rst", gpio_o[2],  0);
        chk("ar_gpio_o",   gpio_o,     64'h1);
        chk("ar_busy",     busy,       0);
        chk("ar_clk_cnt",  clk_count,  0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("ar_idle_bsy", busy,   0);
        chk("ar_idle_gpo", gpio_o, 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
